// File: rtl/stencil_pkg.sv
// Shared types and default sizes for the stencil window path.
// column_t is the unit handed over by the transpose buffer: STENCIL_HEIGHT
// pixels, index 0 being the top row of the strip.
package stencil_pkg;

    localparam int DEF_PIXEL_WIDTH    = 16;
    localparam int DEF_STENCIL_HEIGHT = 2;
    localparam int DEF_STENCIL_WIDTH  = 3;
    localparam int DEF_IMAGE_WIDTH    = 8;

    typedef logic [DEF_PIXEL_WIDTH-1:0] pixel_t;
    typedef pixel_t [DEF_STENCIL_HEIGHT-1:0] column_t;

endpackage

// File: rtl/column_shift_reg.sv
// DEPTH-deep shift register of columns.
// Ports:
//   clk      rising-edge clock
//   clr      synchronous clear of every stage
//   shift_en shift the window by one column, col_in entering at the newest end
//   col_in   incoming column
//   window   [0] oldest column, [DEPTH-1] newest column
module column_shift_reg
    import stencil_pkg::*;
#(
    parameter int DEPTH = DEF_STENCIL_WIDTH
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 shift_en,
    input  column_t              col_in,
    output column_t [DEPTH-1:0]  window
);

    always_ff @(posedge clk) begin
        if (clr) begin
            window <= '0;
        end else if (shift_en) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                window[i] <= window[i+1];
            end
            window[DEPTH-1] <= col_in;
        end
    end

endmodule

// File: rtl/stencil_column_window.sv
// Builds STENCIL_HEIGHT x STENCIL_WIDTH stencils from a stream of columns.
// Each accepted column shifts into the window; once STENCIL_WIDTH columns of
// the current strip have arrived, every further accepted column yields a
// registered stencil. Windows never span two strips of IMAGE_WIDTH columns.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   col_pixels     incoming column, [0] top row
//   col_valid      column handshake valid
//   col_ready      column handshake ready (combinational from output side)
//   stencil        window, [0] oldest column, [STENCIL_WIDTH-1] newest
//   stencil_valid  window is complete and offered downstream
//   stencil_ready  downstream accepts the window
//   stencil_last   window ends on the last column of the strip
module stencil_column_window
    import stencil_pkg::*;
#(
    parameter int PIXEL_WIDTH    = DEF_PIXEL_WIDTH,
    parameter int STENCIL_HEIGHT = DEF_STENCIL_HEIGHT,
    parameter int STENCIL_WIDTH  = DEF_STENCIL_WIDTH,
    parameter int IMAGE_WIDTH    = DEF_IMAGE_WIDTH
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic [STENCIL_HEIGHT-1:0][PIXEL_WIDTH-1:0]            col_pixels,
    input  logic                                                  col_valid,
    output logic                                                  col_ready,
    output logic [STENCIL_WIDTH-1:0][STENCIL_HEIGHT-1:0][PIXEL_WIDTH-1:0] stencil,
    output logic                                                  stencil_valid,
    input  logic                                                  stencil_ready,
    output logic                                                  stencil_last
);

    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int FW = $clog2(STENCIL_WIDTH + 1);

    logic [CW-1:0]                col_count;
    logic [FW-1:0]                fill_count;
    logic                         accept;
    logic                         strip_end;
    logic                         completes;
    column_t                      col_in;
    column_t [STENCIL_WIDTH-1:0]  window;

    // A held stencil blocks new columns: shifting would corrupt it.
    assign col_ready = !stencil_valid || stencil_ready;
    assign accept    = col_valid && col_ready;
    assign strip_end = (col_count == CW'(IMAGE_WIDTH - 1));
    // True when the column being accepted fills (or keeps full) the window.
    assign completes = (int'(fill_count) + 1 >= STENCIL_WIDTH);

    assign col_in  = col_pixels;
    assign stencil = window;

    column_shift_reg #(
        .DEPTH (STENCIL_WIDTH)
    ) u_shift (
        .clk      (clk),
        .clr      (!rst_n),
        .shift_en (accept),
        .col_in   (col_in),
        .window   (window)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_count     <= '0;
            fill_count    <= '0;
            stencil_valid <= 1'b0;
            stencil_last  <= 1'b0;
        end else if (accept) begin
            if (strip_end) begin
                // Next column starts a fresh strip with an empty window.
                col_count  <= '0;
                fill_count <= '0;
            end else begin
                col_count <= col_count + CW'(1);
                if (fill_count != FW'(STENCIL_WIDTH)) begin
                    fill_count <= fill_count + FW'(1);
                end
            end
            stencil_valid <= completes;
            // The strip's last column always completes a window.
            stencil_last  <= strip_end;
        end else if (stencil_ready) begin
            stencil_valid <= 1'b0;
            stencil_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stencil_column_window.sv
module tb_stencil_column_window;

    localparam int SW = 3;
    localparam int IW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic [1:0][15:0]        col_pixels;
    logic                    col_valid;
    logic                    col_ready;
    logic [2:0][1:0][15:0]   stencil;
    logic                    stencil_valid;
    logic                    stencil_ready;
    logic                    stencil_last;

    logic [1:0][15:0]        c1_pixels;
    logic                    c1_valid;
    logic                    c1_ready;
    logic [0:0][1:0][15:0]   stencil1;
    logic                    s1_valid;
    logic                    s1_ready;
    logic                    s1_last;

    stencil_column_window dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .col_pixels    (col_pixels),
        .col_valid     (col_valid),
        .col_ready     (col_ready),
        .stencil       (stencil),
        .stencil_valid (stencil_valid),
        .stencil_ready (stencil_ready),
        .stencil_last  (stencil_last)
    );

    stencil_column_window #(
        .STENCIL_WIDTH (1),
        .IMAGE_WIDTH   (2)
    ) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .col_pixels    (c1_pixels),
        .col_valid     (c1_valid),
        .col_ready     (c1_ready),
        .stencil       (stencil1),
        .stencil_valid (s1_valid),
        .stencil_ready (s1_ready),
        .stencil_last  (s1_last)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the columns accepted so far in the current strip.
    logic [31:0] strip_q[$];
    logic        exp_valid;
    logic        exp_last;
    logic [95:0] exp_win;
    int          n_valid;
    int          n_last;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int c);
        return {16'(2 * c + 1), 16'(2 * c)};
    endfunction

    task automatic model_reset();
        strip_q.delete();
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        exp_win   = '0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        col_valid     = 1'($urandom_range(0, 1));
        col_pixels    = $urandom;
        stencil_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        col_valid = 1'b0;
        model_reset();
        chk("rst_valid", 128'(stencil_valid), 128'(1'b0));
        chk("rst_last", 128'(stencil_last), 128'(1'b0));
        chk("rst_stencil", 128'(stencil), 128'(0));
        chk("rst_col_ready", 128'(col_ready), 128'(1'b1));
    endtask

    // One clock: drive inputs, check col_ready, advance model, check outputs.
    task automatic cyc(input logic v, input logic [31:0] d, input logic sr);
        logic acc;
        int   n;
        col_valid     = v;
        col_pixels    = d;
        stencil_ready = sr;
        #1;
        chk("col_ready", 128'(col_ready), 128'(!exp_valid || sr));
        acc = v && (!exp_valid || sr);
        @(posedge clk);
        if (acc) begin
            strip_q.push_back(d);
            n = strip_q.size();
            if (n >= SW) begin
                exp_valid = 1'b1;
                for (int k = 0; k < SW; k++) exp_win[k*32 +: 32] = strip_q[n-SW+k];
                exp_last = (n == IW);
            end else begin
                exp_valid = 1'b0;
                exp_last  = 1'b0;
            end
            if (n == IW) strip_q.delete();
        end else if (sr) begin
            exp_valid = 1'b0;
            exp_last  = 1'b0;
        end
        #1;
        chk("stencil_valid", 128'(stencil_valid), 128'(exp_valid));
        chk("stencil_last", 128'(stencil_last), 128'(exp_last));
        if (exp_valid) chk("stencil", 128'(stencil), 128'(exp_win));
        if (stencil_valid) n_valid++;
        if (stencil_valid && stencil_last) n_last++;
    endtask

    initial begin
        int          acc1;
        logic        v1;
        logic [31:0] d1;

        rst_n         = 1'b0;
        col_valid     = 1'b0;
        col_pixels    = '0;
        stencil_ready = 1'b1;
        c1_valid      = 1'b0;
        c1_pixels     = '0;
        s1_ready      = 1'b1;
        model_reset();

        do_reset();

        // One full strip at full throughput.
        n_valid = 0;
        n_last  = 0;
        for (int c = 0; c < 8; c++) cyc(1'b1, pat(c), 1'b1);
        chk("strip_stencil_count", 128'(n_valid), 128'(6));
        chk("strip_last_count", 128'(n_last), 128'(1));

        // Next strip: no window across the boundary.
        for (int c = 8; c < 11; c++) cyc(1'b1, pat(c), 1'b1);

        // Backpressure while a stencil is pending, then release.
        for (int i = 0; i < 4; i++) cyc(1'b1, $urandom, 1'b0);
        for (int c = 11; c < 16; c++) cyc(1'b1, pat(c), 1'b1);

        // Gapped input: one-cycle pulses per completing column.
        for (int i = 0; i < 16; i++) cyc(1'((i % 2) == 0), $urandom, 1'b1);

        // Reset while a stencil is held.
        for (int c = 0; c < 5; c++) cyc(1'b1, pat(c), 1'b1);
        cyc(1'b0, $urandom, 1'b0);
        do_reset();
        for (int c = 0; c < 3; c++) cyc(1'b1, pat(c), 1'b1);
        cyc(1'b0, $urandom, 1'b1);

        // Random traffic on both sides.
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));
        col_valid = 1'b0;

        // Single-column window over two-column strips.
        acc1 = 0;
        for (int i = 0; i < 16; i++) begin
            v1 = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            d1 = $urandom;
            c1_valid  = v1;
            c1_pixels = d1;
            #1;
            chk("w1_col_ready", 128'(c1_ready), 128'(1'b1));
            @(posedge clk);
            #1;
            if (v1) begin
                acc1++;
                chk("w1_valid", 128'(s1_valid), 128'(1'b1));
                chk("w1_stencil", 128'(stencil1), 128'(d1));
                chk("w1_last", 128'(s1_last), 128'((acc1 % 2) == 0));
            end else begin
                chk("w1_idle_valid", 128'(s1_valid), 128'(1'b0));
            end
        end
        c1_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
